// File: rtl/racer_pkg.sv
// Shared definitions for the racer-state packet path.
// Holds the 44-bit packet field map, the decoded kart state type, the
// ordered drop classification and helpers that turn a raw packet into
// either a drop reason or a racer_state_t.
package racer_pkg;

  localparam int unsigned PKT_W   = 44;
  localparam int unsigned ID_W    = 3;
  localparam int unsigned POS_W   = 11;
  localparam int unsigned DIR_W   = 9;
  localparam int unsigned GAME_W  = 3;
  localparam int unsigned DIR_MAX = 359;
  localparam int unsigned FCNT_W  = 8;

  // Field map; bits 32, 20, 4 and 2:0 carry nothing.
  localparam int unsigned X_MSB    = 43;
  localparam int unsigned X_LSB    = 33;
  localparam int unsigned Y_MSB    = 31;
  localparam int unsigned Y_LSB    = 21;
  localparam int unsigned DIR_MSB  = 19;
  localparam int unsigned DIR_LSB  = 11;
  localparam int unsigned ID_MSB   = 10;
  localparam int unsigned ID_LSB   = 8;
  localparam int unsigned GAME_MSB = 7;
  localparam int unsigned GAME_LSB = 5;
  localparam int unsigned RST_BIT  = 3;

  typedef struct packed {
    logic [POS_W-1:0]  x;
    logic [POS_W-1:0]  y;
    logic [DIR_W-1:0]  dir;
    logic [GAME_W-1:0] game;
  } racer_state_t;

  // Drop reasons in priority order; the first rule that matches wins.
  typedef enum logic [2:0] {
    DROP_NONE,
    DROP_ZERO,
    DROP_ID_RANGE,
    DROP_SELF,
    DROP_DIR
  } drop_t;

  function automatic racer_state_t pkt_to_state(input logic [PKT_W-1:0] pkt);
    racer_state_t s;
    s.x    = pkt[X_MSB:X_LSB];
    s.y    = pkt[Y_MSB:Y_LSB];
    s.dir  = pkt[DIR_MSB:DIR_LSB];
    s.game = pkt[GAME_MSB:GAME_LSB];
    return s;
  endfunction

  function automatic logic [ID_W-1:0] pkt_to_id(input logic [PKT_W-1:0] pkt);
    return pkt[ID_MSB:ID_LSB];
  endfunction

  function automatic drop_t classify(input logic [PKT_W-1:0] pkt,
                                     input logic [ID_W-1:0]  self_id,
                                     input int unsigned      num_players);
    logic [ID_W-1:0]  id;
    logic [DIR_W-1:0] dir;
    id  = pkt[ID_MSB:ID_LSB];
    dir = pkt[DIR_MSB:DIR_LSB];
    if (pkt == '0)                     return DROP_ZERO;
    else if (32'(id) >= num_players)   return DROP_ID_RANGE;
    else if (id == self_id)            return DROP_SELF;
    else if (32'(dir) > DIR_MAX)       return DROP_DIR;
    else                               return DROP_NONE;
  endfunction

endpackage

// File: rtl/player_slot.sv
// One remote racer slot: latched kart state, liveness flag and the
// frame counter that times the slot out.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clear           synchronous clear of state, alive, counter and pulse
//   wr_en           accepted packet addressed to this slot
//   wr_rst          that packet carries the race-reset bit
//   wr_state        decoded fields of that packet
//   frame_tick      one pulse per video frame
//   state           stored fields
//   alive           slot has been written within TIMEOUT_FRAMES frames
//   update          one-cycle pulse when stored fields change or slot revives
module player_slot
  import racer_pkg::*;
#(
  parameter int unsigned TIMEOUT_FRAMES = 60
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         wr_en,
  input  logic         wr_rst,
  input  racer_state_t wr_state,
  input  logic         frame_tick,
  output racer_state_t state,
  output logic         alive,
  output logic         update
);

  localparam logic [FCNT_W-1:0] TIMEOUT = FCNT_W'(TIMEOUT_FRAMES);

  logic [FCNT_W-1:0] frame_cnt;
  logic [FCNT_W-1:0] frame_cnt_inc;

  assign frame_cnt_inc = frame_cnt + FCNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= '0;
      alive     <= 1'b0;
      frame_cnt <= '0;
      update    <= 1'b0;
    end else if (clear) begin
      state     <= '0;
      alive     <= 1'b0;
      frame_cnt <= '0;
      update    <= 1'b0;
    end else begin
      update <= 1'b0;
      // A write takes priority over a coincident frame tick.
      if (wr_en) begin
        alive     <= 1'b1;
        frame_cnt <= '0;
        if (wr_rst) begin
          state  <= '0;
          update <= 1'b1;
        end else begin
          state  <= wr_state;
          update <= (state != wr_state) || !alive;
        end
      end else if (frame_tick && alive) begin
        // Count freezes once the timeout is reached because alive drops.
        frame_cnt <= frame_cnt_inc;
        if (frame_cnt_inc == TIMEOUT) begin
          alive <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/opponent_tracker.sv
// Decodes racer-state packets from the Ethernet receive path, drops
// invalid and self-echoed packets, and keeps per-player kart state with
// frame-based liveness for the renderers.
// Ports:
//   clk_in, rst_in   clock, asynchronous active-high reset
//   clear_in         synchronous clear of all slots and counters
//   self_id          local player id; packets with this id are dropped
//   pkt_valid        one-cycle strobe qualifying pkt_data
//   pkt_data         raw 44-bit packet
//   frame_tick       one pulse per video frame
//   player_x/y/dir/game  per-slot stored fields, slot i at [i*W +: W]
//   player_alive     per-slot liveness
//   player_update    per-slot one-cycle change pulse
//   remote_reset     one-cycle pulse on an accepted reset packet
//   accept_cnt, drop_cnt  saturating packet counters
module opponent_tracker
  import racer_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS    = 2,
  parameter int unsigned TIMEOUT_FRAMES = 60,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          clear_in,
  input  logic [ID_W-1:0]               self_id,
  input  logic                          pkt_valid,
  input  logic [PKT_W-1:0]              pkt_data,
  input  logic                          frame_tick,
  output logic [NUM_PLAYERS*POS_W-1:0]  player_x,
  output logic [NUM_PLAYERS*POS_W-1:0]  player_y,
  output logic [NUM_PLAYERS*DIR_W-1:0]  player_dir,
  output logic [NUM_PLAYERS*GAME_W-1:0] player_game,
  output logic [NUM_PLAYERS-1:0]        player_alive,
  output logic [NUM_PLAYERS-1:0]        player_update,
  output logic                          remote_reset,
  output logic [CNT_W-1:0]              accept_cnt,
  output logic [CNT_W-1:0]              drop_cnt
);

  drop_t           reason;
  logic            accept;
  logic            dropped;
  logic [ID_W-1:0] pkt_id;
  logic            pkt_rst;
  racer_state_t    pkt_state;

  assign reason    = classify(pkt_data, self_id, NUM_PLAYERS);
  assign pkt_id    = pkt_to_id(pkt_data);
  assign pkt_rst   = pkt_data[RST_BIT];
  assign pkt_state = pkt_to_state(pkt_data);
  assign accept    = pkt_valid && (reason == DROP_NONE);
  assign dropped   = pkt_valid && (reason != DROP_NONE);

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_slot
    racer_state_t slot_state;

    player_slot #(
      .TIMEOUT_FRAMES(TIMEOUT_FRAMES)
    ) u_slot (
      .clk        (clk_in),
      .rst        (rst_in),
      .clear      (clear_in),
      .wr_en      (accept && (pkt_id == ID_W'(i))),
      .wr_rst     (pkt_rst),
      .wr_state   (pkt_state),
      .frame_tick (frame_tick),
      .state      (slot_state),
      .alive      (player_alive[i]),
      .update     (player_update[i])
    );

    assign player_x[i*POS_W +: POS_W]     = slot_state.x;
    assign player_y[i*POS_W +: POS_W]     = slot_state.y;
    assign player_dir[i*DIR_W +: DIR_W]   = slot_state.dir;
    assign player_game[i*GAME_W +: GAME_W] = slot_state.game;
  end

  // Clear outranks a coincident packet, which is then neither counted nor stored.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      remote_reset <= 1'b0;
      accept_cnt   <= '0;
      drop_cnt     <= '0;
    end else if (clear_in) begin
      remote_reset <= 1'b0;
      accept_cnt   <= '0;
      drop_cnt     <= '0;
    end else begin
      remote_reset <= accept && pkt_rst;
      if (accept && (accept_cnt != '1)) begin
        accept_cnt <= accept_cnt + CNT_W'(1);
      end
      if (dropped && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_opponent_tracker.sv
module tb_opponent_tracker;

  localparam int NP  = 2;
  localparam int TO  = 3;
  localparam int CW  = 4;
  localparam int SAT = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear = 1'b0;
  logic [2:0]        self_id = 3'd0;
  logic              pkt_valid = 1'b0;
  logic [43:0]       pkt_data = '0;
  logic              frame_tick = 1'b0;
  logic [NP*11-1:0]  player_x, player_y;
  logic [NP*9-1:0]   player_dir;
  logic [NP*3-1:0]   player_game;
  logic [NP-1:0]     player_alive, player_update;
  logic              remote_reset;
  logic [CW-1:0]     accept_cnt, drop_cnt;

  opponent_tracker #(
    .NUM_PLAYERS(NP),
    .TIMEOUT_FRAMES(TO),
    .CNT_W(CW)
  ) dut (
    .clk_in(clk), .rst_in(rst), .clear_in(clear), .self_id(self_id),
    .pkt_valid(pkt_valid), .pkt_data(pkt_data), .frame_tick(frame_tick),
    .player_x(player_x), .player_y(player_y), .player_dir(player_dir),
    .player_game(player_game), .player_alive(player_alive),
    .player_update(player_update), .remote_reset(remote_reset),
    .accept_cnt(accept_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: plain per-player records and counts.
  int m_x[NP], m_y[NP], m_dir[NP], m_game[NP], m_frames[NP];
  bit m_alive[NP];
  bit m_upd[NP];
  bit m_rr;
  int m_acc, m_drop;

  function automatic logic [43:0] mk(input int x, input int y, input int dir,
                                     input int id, input int game, input int r);
    logic [43:0] p;
    p = '0;
    p[43:33] = x[10:0];
    p[31:21] = y[10:0];
    p[19:11] = dir[8:0];
    p[10:8]  = id[2:0];
    p[7:5]   = game[2:0];
    p[3]     = r[0];
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_dir[i] = 0; m_game[i] = 0;
      m_frames[i] = 0; m_alive[i] = 0; m_upd[i] = 0;
    end
    m_rr = 0; m_acc = 0; m_drop = 0;
  endtask

  task automatic model_step(input bit v, input logic [43:0] d, input bit tick,
                            input bit clr, input int self);
    bit was_alive[NP];
    int fx, fy, fdir, fid, fgame;
    bit fr;
    if (clr) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NP; i++) begin
      was_alive[i] = m_alive[i];
      m_upd[i] = 0;
    end
    m_rr = 0;
    if (tick) begin
      for (int i = 0; i < NP; i++) begin
        if (m_alive[i]) begin
          m_frames[i]++;
          if (m_frames[i] == TO) m_alive[i] = 0;
        end
      end
    end
    if (v) begin
      fx = int'(d[43:33]); fy = int'(d[31:21]); fdir = int'(d[19:11]);
      fid = int'(d[10:8]); fgame = int'(d[7:5]); fr = d[3];
      if (d == 0 || fid >= NP || fid == self || fdir > 359) begin
        if (m_drop < SAT) m_drop++;
      end else begin
        if (m_acc < SAT) m_acc++;
        if (fr) begin
          m_rr = 1;
          m_x[fid] = 0; m_y[fid] = 0; m_dir[fid] = 0; m_game[fid] = 0;
          m_upd[fid] = 1;
        end else begin
          if (m_x[fid] != fx || m_y[fid] != fy || m_dir[fid] != fdir ||
              m_game[fid] != fgame || !was_alive[fid])
            m_upd[fid] = 1;
          m_x[fid] = fx; m_y[fid] = fy; m_dir[fid] = fdir; m_game[fid] = fgame;
        end
        m_alive[fid] = 1;
        m_frames[fid] = 0;
      end
    end
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [NP-1:0] ea, eu;
    for (int i = 0; i < NP; i++) begin
      check($sformatf("%s x%0d", tag, i), longint'(player_x[i*11 +: 11]), m_x[i]);
      check($sformatf("%s y%0d", tag, i), longint'(player_y[i*11 +: 11]), m_y[i]);
      check($sformatf("%s dir%0d", tag, i), longint'(player_dir[i*9 +: 9]), m_dir[i]);
      check($sformatf("%s game%0d", tag, i), longint'(player_game[i*3 +: 3]), m_game[i]);
      ea[i] = m_alive[i];
      eu[i] = m_upd[i];
    end
    check({tag, " alive"}, longint'(player_alive), longint'(ea));
    check({tag, " update"}, longint'(player_update), longint'(eu));
    check({tag, " remote_reset"}, longint'(remote_reset), longint'(m_rr));
    check({tag, " accept_cnt"}, longint'(accept_cnt), m_acc);
    check({tag, " drop_cnt"}, longint'(drop_cnt), m_drop);
  endtask

  task automatic step(input string tag, input bit v, input logic [43:0] d,
                      input bit tick, input bit clr, input int self);
    @(negedge clk);
    pkt_valid = v; pkt_data = d; frame_tick = tick; clear = clr;
    self_id = self[2:0];
    model_step(v, d, tick, clr, self);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    bit v; int x; int y; int dir; int id; int game; int r;
    bit tick; bit clr; int self;
    bit [1:0] e_upd; bit e_rr; int e_acc; int e_drop; bit [1:0] e_alive;
    int e_x0; int e_x1;
  } vec_t;

  vec_t vt[$];

  initial begin
    logic [43:0] d;
    int self_r;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    @(negedge clk);
    rst = 1'b0;

    //        v  x    y    dir id game r tick clr self upd   rr acc drop alive x0 x1
    vt.push_back('{1, 100, 200, 90, 1, 2, 0, 0, 0, 0, 2'b10, 0, 1, 0, 2'b10, 0, 100});
    vt.push_back('{1, 100, 200, 90, 1, 2, 0, 0, 0, 0, 2'b00, 0, 2, 0, 2'b10, 0, 100});
    vt.push_back('{1, 0,   0,   0,  0, 0, 0, 0, 0, 0, 2'b00, 0, 2, 1, 2'b10, 0, 100});
    vt.push_back('{1, 7,   7,   7,  0, 1, 0, 0, 0, 0, 2'b00, 0, 2, 2, 2'b10, 0, 100});
    vt.push_back('{1, 7,   7,   7,  5, 1, 0, 0, 0, 0, 2'b00, 0, 2, 3, 2'b10, 0, 100});
    vt.push_back('{1, 7,   7,   400, 1, 1, 0, 0, 0, 0, 2'b00, 0, 2, 4, 2'b10, 0, 100});
    vt.push_back('{0, 0,   0,   0,  0, 0, 0, 1, 0, 0, 2'b00, 0, 2, 4, 2'b10, 0, 100});
    vt.push_back('{0, 0,   0,   0,  0, 0, 0, 1, 0, 0, 2'b00, 0, 2, 4, 2'b10, 0, 100});
    vt.push_back('{1, 100, 200, 90, 1, 2, 0, 1, 0, 0, 2'b00, 0, 3, 4, 2'b10, 0, 100});
    vt.push_back('{0, 0,   0,   0,  0, 0, 0, 1, 0, 0, 2'b00, 0, 3, 4, 2'b10, 0, 100});
    vt.push_back('{0, 0,   0,   0,  0, 0, 0, 1, 0, 0, 2'b00, 0, 3, 4, 2'b10, 0, 100});
    vt.push_back('{0, 0,   0,   0,  0, 0, 0, 1, 0, 0, 2'b00, 0, 3, 4, 2'b00, 0, 100});
    vt.push_back('{0, 0,   0,   0,  0, 0, 0, 1, 0, 0, 2'b00, 0, 3, 4, 2'b00, 0, 100});
    vt.push_back('{1, 100, 200, 90, 1, 2, 0, 0, 0, 0, 2'b10, 0, 4, 4, 2'b10, 0, 100});
    vt.push_back('{1, 5,   6,   7,  0, 1, 0, 0, 0, 3, 2'b01, 0, 5, 4, 2'b11, 5, 100});
    vt.push_back('{1, 9,   9,   9,  1, 1, 1, 0, 0, 3, 2'b10, 1, 6, 4, 2'b11, 5, 0});
    vt.push_back('{0, 0,   0,   0,  0, 0, 0, 0, 0, 3, 2'b00, 0, 6, 4, 2'b11, 5, 0});
    vt.push_back('{1, 1,   1,   1,  1, 1, 0, 0, 1, 3, 2'b00, 0, 0, 0, 2'b00, 0, 0});

    foreach (vt[k]) begin
      d = mk(vt[k].x, vt[k].y, vt[k].dir, vt[k].id, vt[k].game, vt[k].r);
      step($sformatf("vec%0d", k), vt[k].v, d, vt[k].tick, vt[k].clr, vt[k].self);
      check($sformatf("vec%0d t_upd", k), longint'(player_update), longint'(vt[k].e_upd));
      check($sformatf("vec%0d t_rr", k), longint'(remote_reset), longint'(vt[k].e_rr));
      check($sformatf("vec%0d t_acc", k), longint'(accept_cnt), vt[k].e_acc);
      check($sformatf("vec%0d t_drop", k), longint'(drop_cnt), vt[k].e_drop);
      check($sformatf("vec%0d t_alive", k), longint'(player_alive), longint'(vt[k].e_alive));
      check($sformatf("vec%0d t_x0", k), longint'(player_x[10:0]), vt[k].e_x0);
      check($sformatf("vec%0d t_x1", k), longint'(player_x[21:11]), vt[k].e_x1);
    end

    // Counter saturation at all-ones.
    for (int k = 0; k < 17; k++)
      step("sat_acc", 1, mk(k, 1, 1, 1, 0, 0), 0, 0, 3);
    check("acc_saturated", longint'(accept_cnt), SAT);
    for (int k = 0; k < 17; k++)
      step("sat_drop", 1, mk(k, 1, 400, 1, 0, 0), 0, 0, 3);
    check("drop_saturated", longint'(drop_cnt), SAT);
    step("clr", 0, '0, 0, 1, 3);

    // Back-to-back packets, then asynchronous reset mid-burst.
    step("b2b0", 1, mk(11, 2, 3, 0, 1, 0), 0, 0, 3);
    step("b2b1", 1, mk(22, 2, 3, 1, 1, 0), 0, 0, 3);
    check("b2b x0", longint'(player_x[10:0]), 11);
    check("b2b x1", longint'(player_x[21:11]), 22);
    check("b2b upd", longint'(player_update), 2);
    @(negedge clk);
    pkt_valid = 1'b1; pkt_data = mk(33, 2, 3, 0, 1, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst x", longint'(player_x), 0);
    check("rst alive", longint'(player_alive), 0);
    check("rst upd", longint'(player_update), 0);
    check("rst acc", longint'(accept_cnt), 0);
    check("rst drop", longint'(drop_cnt), 0);
    check_model("rst");
    @(negedge clk);
    pkt_valid = 1'b0;
    @(posedge clk);
    #1;
    check_model("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 1, mk(44, 5, 6, 1, 2, 0), 0, 0, 3);
    check("post_rst acc", longint'(accept_cnt), 1);
    check("post_rst x1", longint'(player_x[21:11]), 44);

    // Randomized traffic against the model.
    self_r = 0;
    for (int k = 0; k < 400; k++) begin
      if (k % 50 == 0) self_r = int'($urandom_range(0, 3));
      d = mk(int'($urandom_range(0, 2)) * 100, int'($urandom_range(0, 1)) * 50,
             ($urandom_range(0, 9) == 0) ? int'($urandom_range(360, 511))
                                         : int'($urandom_range(0, 2)) * 120,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0) ? 1 : 0);
      d = d | (44'h1_0010_0017 & {12'h0, $urandom()});
      d[32] = $urandom_range(0, 1);
      if ($urandom_range(0, 19) == 0) d = '0;
      step("rand", $urandom_range(0, 1) == 1, d, $urandom_range(0, 3) == 0,
           $urandom_range(0, 59) == 0, self_r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/opponent_tracker.md
Name: opponent_tracker

Overview:
- Decodes 44-bit racer-state packets arriving from the Ethernet receive path.
- Filters out invalid and self-echoed packets, and latches per-player kart state for up to NUM_PLAYERS remote racers.
- Tracks liveness per player with a frame-based timeout and surfaces remote race-reset requests.
- Sits between receive and the track/racer view renderers; replaces ad-hoc field slicing and buffering in the top level.

Parameters:
- NUM_PLAYERS, 2, number of player slots (1..8); slot index = packet player id.
- TIMEOUT_FRAMES, 60, frame_tick pulses without an accepted update before a slot is marked not alive (1..255).
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk_in  input  1  system clock (eth_refclk domain).
- rst_in  input  1  asynchronous active-high reset.
- clear_in  input  1  synchronous soft clear of all slots and counters.
- self_id  input  3  local player id; packets carrying this id are dropped.
- pkt_valid  input  1  one-cycle strobe; pkt_data is valid this cycle.
- pkt_data  input  44  raw packet.
- frame_tick  input  1  one-cycle pulse per video frame.
- player_x  output  NUM_PLAYERS*11  per-slot x position.
- player_y  output  NUM_PLAYERS*11  per-slot y position.
- player_dir  output  NUM_PLAYERS*9  per-slot heading, degrees.
- player_game  output  NUM_PLAYERS*3  per-slot game status.
- player_alive  output  NUM_PLAYERS  slot has had an accepted update within the timeout window.
- player_update  output  NUM_PLAYERS  one-cycle pulse when a slot's stored fields change.
- remote_reset  output  1  one-cycle pulse when an accepted packet carries the reset bit.
- accept_cnt  output  CNT_W  accepted packet count.
- drop_cnt  output  CNT_W  dropped packet count.

Behaviour:
- Packet fields:
  - x = [43:33], y = [31:21], dir = [19:11], id = [10:8], game = [7:5], rst = [3].
  - Bits 32, 20, 4 and 2:0 are ignored.
- Drop rules, evaluated in the pkt_valid cycle, in this order:
  - pkt_data == 0;
  - id >= NUM_PLAYERS;
  - id == self_id;
  - dir > 359.
- A dropped packet increments drop_cnt and has no other effect.
- An accepted packet increments accept_cnt.
- Latency: with pkt_valid at edge N, slot registers, player_update, remote_reset and counters take new values after edge N+1, i.e. they are registered outputs and visible one cycle later.
- Slot write on an accepted packet with rst == 0:
  - store x, y, dir, game;
  - set alive = 1;
  - zero the slot's frame counter;
  - pulse player_update[id] only if any stored field differs from the incoming value, or alive was 0.
- Accepted packet with rst == 1:
  - pulse remote_reset;
  - slot id fields are cleared to 0, alive = 1, frame counter zeroed;
  - player_update[id] is pulsed;
  - other slots are untouched.
- frame_tick: every alive slot increments its frame counter. A counter reaching TIMEOUT_FRAMES sets alive = 0 and holds the count. Stored fields are retained and not cleared.
- Simultaneous frame_tick and accepted packet for the same slot: the packet wins; the counter is 0 after the edge and alive = 1.
- Counters saturate at all-ones; they do not wrap.
- Reset (rst_in, async) and clear_in (sync, same effect at the next edge):
  - all fields 0, alive 0, frame counters 0;
  - player_update 0, remote_reset 0, accept_cnt 0, drop_cnt 0.
- clear_in coincident with pkt_valid: the clear wins and the packet is discarded uncounted.
- rst_in asserted mid-stream: outputs go to reset values immediately; the first packet after deassertion is processed normally.
- No back-pressure: back-to-back pkt_valid on consecutive cycles is fully supported, one packet per cycle.

Decomposition:
- racer_pkg holds:
  - field MSB/LSB localparams;
  - PKT_W = 44, ID_W = 3, POS_W = 11, DIR_W = 9, GAME_W = 3, DIR_MAX = 359;
  - typedef racer_state_t (packed struct: x, y, dir, game);
  - a decode function pkt_to_state.
- Sub-module player_slot, instantiated NUM_PLAYERS times:
  - holds racer_state_t, alive and the frame counter;
  - inputs: wr_en, wr_rst, wr_state, frame_tick, clear;
  - outputs: state, alive, update pulse.
- The top of the block handles decode, filtering, id demux and the counters.

Test Plan:
- Reset then x=100, y=200, dir=90, id=1, game=2, self_id=0 -> after one cycle, slot1 x=100, y=200, dir=90, game=2; alive[1]=1; player_update=2'b10 for one cycle; accept_cnt=1.
- Same packet resent -> no player_update pulse; accept_cnt=2; fields unchanged.
- Packets with all-zero data, id=0 (self), id=5 (NUM_PLAYERS=2) and dir=400 -> drop_cnt=4, accept_cnt unchanged, no slot changes.
- TIMEOUT_FRAMES=3, update slot1 then 3 frame_ticks -> alive[1] falls after the 3rd tick with x=100 retained; a new packet on the same cycle as the 3rd tick keeps alive[1]=1.
- Accepted packet for id=1 with rst=1 -> remote_reset high for exactly one cycle; slot1 fields 0; slot0 unchanged.
- Back-to-back accepted packets for id=0 and id=1 on consecutive cycles, then rst_in pulsed mid-burst -> both slots updated before reset; all outputs 0 during rst_in; counters 0 afterwards.
